// File: rtl/rx_frame_buffer.sv
// RX frame buffer: checks the SFD tail, stores the payload, verifies CRC-16-CCITT
// and streams a verified payload over a valid/ready interface.
//
// Ports:
//   clk4m       system clock, all logic on the rising edge
//   reset       synchronous active-high reset
//   byte_in     decoded byte from the synchroniser
//   byte_valid  1-cycle strobe qualifying byte_in
//   out_data    payload byte towards the UART path (registered)
//   out_valid   out_data valid
//   out_ready   consumer accepts on out_valid && out_ready
//   out_last    high together with the final payload byte
//   frame_ok    1-cycle pulse, CRC matched
//   frame_err   1-cycle pulse, bad SFD tail, CRC mismatch or inter-byte timeout
//   frame_drop  1-cycle pulse per byte ignored while draining
//   busy        high in every state except IDLE
module rx_frame_buffer #(
    parameter int         PAYLOAD_LEN = 146,
    parameter logic [7:0] SFD_TAIL    = 8'hF3,
    parameter int         TIMEOUT     = 4096
) (
    input  logic       clk4m,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       frame_drop,
    output logic       busy
);

    localparam int IW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CRC_HI,
        CRC_LO,
        CHECK,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] wr_idx_n;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] rd_idx_n;
    logic [IW-1:0] rd_next;
    logic [15:0]   crc;
    logic [15:0]   crc_n;
    logic [7:0]    rx_crc_hi;
    logic [7:0]    rx_crc_hi_n;
    logic [TW-1:0] idle_cnt;
    logic [TW-1:0] idle_cnt_n;
    logic [7:0]    out_data_n;
    logic          out_valid_n;
    logic          out_last_n;
    logic          frame_ok_n;
    logic          frame_err_n;
    logic          frame_drop_n;
    logic          in_frame;

    logic [7:0]    ram [0:PAYLOAD_LEN-1];
    logic          ram_we;
    logic [IW-1:0] ram_raddr;
    logic [7:0]    ram_rdata;

    // CRC-16-CCITT, MSB first, one whole byte per clock.
    function automatic logic [15:0] crc_byte(
        input logic [15:0] c,
        input logic [7:0]  d
    );
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    assign busy     = (state != IDLE);
    assign in_frame = (state == RECV) || (state == CRC_HI) ||
                      (state == CRC_LO);
    assign rd_next  = rd_idx + 1'b1;

    // Address the byte that will be presented after the current accept;
    // index 0 is preloaded while in CHECK.
    assign ram_raddr = (state == DRAIN && !out_last) ? rd_next : '0;
    assign ram_rdata = ram[ram_raddr];

    always_ff @(posedge clk4m) begin
        if (ram_we) begin
            ram[wr_idx] <= byte_in;
        end
    end

    always_comb begin
        state_n      = state;
        wr_idx_n     = wr_idx;
        rd_idx_n     = rd_idx;
        crc_n        = crc;
        rx_crc_hi_n  = rx_crc_hi;
        idle_cnt_n   = '0;
        out_data_n   = out_data;
        out_valid_n  = out_valid;
        out_last_n   = out_last;
        frame_ok_n   = 1'b0;
        frame_err_n  = 1'b0;
        frame_drop_n = 1'b0;
        ram_we       = 1'b0;

        if (in_frame) begin
            idle_cnt_n = byte_valid ? '0 : idle_cnt + 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (byte_valid) begin
                    if (byte_in == SFD_TAIL) begin
                        state_n  = RECV;
                        wr_idx_n = '0;
                        crc_n    = 16'hFFFF;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            RECV: begin
                if (byte_valid) begin
                    ram_we = 1'b1;
                    crc_n  = crc_byte(crc, byte_in);
                    if (wr_idx == LAST_IDX) begin
                        state_n = CRC_HI;
                    end else begin
                        wr_idx_n = wr_idx + 1'b1;
                    end
                end
            end
            CRC_HI: begin
                if (byte_valid) begin
                    rx_crc_hi_n = byte_in;
                    state_n     = CRC_LO;
                end
            end
            CRC_LO: begin
                if (byte_valid) begin
                    state_n = CHECK;
                    if (crc == {rx_crc_hi, byte_in}) begin
                        frame_ok_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            CHECK: begin
                // The verdict was registered into frame_ok on the last CRC byte.
                if (frame_ok) begin
                    state_n     = DRAIN;
                    rd_idx_n    = '0;
                    out_valid_n = 1'b1;
                    out_data_n  = ram_rdata;
                    out_last_n  = (LAST_IDX == '0);
                end else begin
                    state_n = IDLE;
                end
            end
            DRAIN: begin
                frame_drop_n = byte_valid;
                if (out_ready) begin
                    if (out_last) begin
                        state_n     = IDLE;
                        out_valid_n = 1'b0;
                        out_last_n  = 1'b0;
                    end else begin
                        rd_idx_n   = rd_next;
                        out_data_n = ram_rdata;
                        out_last_n = (rd_next == LAST_IDX);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Too long without a byte inside a frame: abandon it.
        if (in_frame && !byte_valid && idle_cnt == TO_LAST) begin
            state_n     = IDLE;
            frame_err_n = 1'b1;
            idle_cnt_n  = '0;
        end
    end

    always_ff @(posedge clk4m) begin
        if (reset) begin
            state      <= IDLE;
            wr_idx     <= '0;
            rd_idx     <= '0;
            crc        <= 16'hFFFF;
            rx_crc_hi  <= '0;
            idle_cnt   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            state      <= state_n;
            wr_idx     <= wr_idx_n;
            rd_idx     <= rd_idx_n;
            crc        <= crc_n;
            rx_crc_hi  <= rx_crc_hi_n;
            idle_cnt   <= idle_cnt_n;
            out_data   <= out_data_n;
            out_valid  <= out_valid_n;
            out_last   <= out_last_n;
            frame_ok   <= frame_ok_n;
            frame_err  <= frame_err_n;
            frame_drop <= frame_drop_n;
        end
    end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Testbench for rx_frame_buffer: directed frames plus randomized traffic,
// checked every cycle against a frame-level reference model.
module tb_rx_frame_buffer;

    localparam int N  = 9;
    localparam int TO = 16;

    logic       clk4m = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byte_in = '0;
    logic       byte_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic       frame_drop;
    logic       busy;

    rx_frame_buffer #(
        .PAYLOAD_LEN(N),
        .SFD_TAIL   (8'hF3),
        .TIMEOUT    (TO)
    ) dut (
        .clk4m     (clk4m),
        .reset     (reset),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .frame_drop(frame_drop),
        .busy      (busy)
    );

    always #5 clk4m = ~clk4m;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC, bit-serial over the first n bytes of a frame.
    function automatic logic [15:0] ref_crc(input logic [7:0] q[$], input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ q[k][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    // ---------------- reference model ----------------
    bit         m_collect = 0;
    bit         m_check = 0;
    bit         m_drain = 0;
    bit         m_okpend = 0;
    int         m_gap = 0;
    logic [7:0] m_rx[$];
    logic [7:0] m_out[$];
    logic       e_ok = 0, e_err = 0, e_drop = 0;
    logic       e_valid = 0, e_last = 0, e_busy = 0;
    logic [7:0] e_data = '0;

    always @(posedge clk4m) begin
        if (reset) begin
            m_collect = 0; m_check = 0; m_drain = 0; m_okpend = 0;
            m_gap = 0; m_rx = {}; m_out = {};
            e_ok = 0; e_err = 0; e_drop = 0;
            e_valid = 0; e_last = 0; e_busy = 0; e_data = '0;
        end else begin
            e_ok = 0; e_err = 0; e_drop = 0;
            if (m_drain) begin
                if (byte_valid) e_drop = 1;
                if (out_ready) begin
                    void'(m_out.pop_front());
                    if (m_out.size() == 0) begin
                        m_drain = 0; e_valid = 0; e_last = 0;
                    end else begin
                        e_data = m_out[0];
                        e_last = (m_out.size() == 1);
                    end
                end
            end else if (m_check) begin
                m_check = 0;
                if (m_okpend) begin
                    m_drain = 1;
                    m_out = {};
                    for (int i = 0; i < N; i++) m_out.push_back(m_rx[i]);
                    e_valid = 1; e_data = m_out[0]; e_last = (N == 1);
                end
            end else if (m_collect) begin
                if (byte_valid) begin
                    m_gap = 0;
                    m_rx.push_back(byte_in);
                    if (m_rx.size() == N + 2) begin
                        m_collect = 0; m_check = 1;
                        m_okpend = (ref_crc(m_rx, N) == {m_rx[N], m_rx[N+1]});
                        e_ok = m_okpend; e_err = !m_okpend;
                    end
                end else begin
                    m_gap++;
                    if (m_gap == TO) begin
                        m_collect = 0; e_err = 1;
                    end
                end
            end else if (byte_valid) begin
                if (byte_in == 8'hF3) begin
                    m_collect = 1; m_rx = {}; m_gap = 0;
                end else begin
                    e_err = 1;
                end
            end
            e_busy = m_collect | m_check | m_drain;
        end
    end

    // ---------------- compare process ----------------
    bit         cmp_en = 0;
    int         drop_cnt = 0;
    logic [7:0] cap_data[$];
    logic       cap_last[$];

    always @(negedge clk4m) begin
        if (cmp_en) begin
            check("busy", busy, e_busy);
            check("frame_ok", frame_ok, e_ok);
            check("frame_err", frame_err, e_err);
            check("frame_drop", frame_drop, e_drop);
            check("out_valid", out_valid, e_valid);
            if (e_valid) begin
                check("out_data", out_data, e_data);
                check("out_last", out_last, e_last);
            end
            if (frame_drop) drop_cnt++;
            if (out_valid && out_ready) begin
                cap_data.push_back(out_data);
                cap_last.push_back(out_last);
            end
        end
    end

    // out_ready pattern: 0 always 1, 1 toggle, 2 random, 3 always 0
    int rdy_mode = 0;
    always @(posedge clk4m) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk4m);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        @(posedge clk4m);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] p[$], input logic [15:0] c,
                              input int maxgap);
        send_byte(8'hF3);
        foreach (p[i]) begin
            idle($urandom_range(0, maxgap));
            send_byte(p[i]);
        end
        idle($urandom_range(0, maxgap));
        send_byte(c[15:8]);
        idle($urandom_range(0, maxgap));
        send_byte(c[7:0]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 500) begin
            idle(1);
            n++;
        end
        check({"wait_idle_", name}, busy, 1'b0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 100) begin
            idle(1);
            n++;
        end
        check({"wait_valid_", name}, out_valid, 1'b1);
    endtask

    function automatic void rand_payload(output logic [7:0] p[$]);
        p = {};
        for (int i = 0; i < N; i++) p.push_back(8'($urandom_range(0, 255)));
    endfunction

    logic [7:0] digits[$];
    logic [7:0] pl[$];
    int         d0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 9; i++) digits.push_back(8'h31 + 8'(i));
        repeat (2) @(posedge clk4m);
        #1;
        cmp_en = 1;
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_drop", frame_drop, 0);
        check("crc_pin", ref_crc(digits, 9), 16'h29B1);
        reset = 1'b0;
        idle(2);

        // 1: good reference frame, free-flowing consumer
        rdy_mode = 0;
        cap_data = {}; cap_last = {};
        send_frame(digits, 16'h29B1, 0);
        @(negedge clk4m);
        check("t1_frame_ok_lat", frame_ok, 1);
        idle(1);
        wait_idle("t1");
        check("t1_count", cap_data.size(), 9);
        for (int i = 0; i < cap_data.size(); i++) begin
            check("t1_data", cap_data[i], 8'h31 + i);
            check("t1_last", cap_last[i], (i == 8));
        end
        idle(2);

        // 2: CRC mismatch
        send_frame(digits, 16'h29B0, 0);
        @(negedge clk4m);
        check("t2_frame_err", frame_err, 1);
        @(negedge clk4m);
        check("t2_busy", busy, 0);
        check("t2_out_valid", out_valid, 0);
        idle(2);

        // 3: bad SFD tail then a good frame
        send_byte(8'hFC);
        @(negedge clk4m);
        check("t3_frame_err", frame_err, 1);
        check("t3_busy", busy, 0);
        idle(1);
        send_frame(digits, 16'h29B1, 0);
        @(negedge clk4m);
        check("t3_frame_ok", frame_ok, 1);
        idle(1);
        wait_idle("t3");

        // 4: timeout boundary
        send_byte(8'hF3);
        for (int i = 0; i < 4; i++) send_byte(digits[i]);
        idle(TO - 1);
        check("t4_no_err_early", frame_err, 0);
        check("t4_busy_early", busy, 1);
        idle(1);
        check("t4_frame_err", frame_err, 1);
        check("t4_busy", busy, 0);
        idle(2);
        send_frame(digits, 16'h29B1, 0);
        @(negedge clk4m);
        check("t4_frame_ok", frame_ok, 1);
        idle(1);
        wait_idle("t4");

        // 5: stalling consumer and drops during drain
        rdy_mode = 1;
        rand_payload(pl);
        cap_data = {}; cap_last = {};
        send_frame(pl, ref_crc(pl, N), 0);
        wait_valid("t5");
        d0 = drop_cnt;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h55);
            idle(1);
        end
        wait_idle("t5");
        check("t5_drops", drop_cnt - d0, 3);
        check("t5_count", cap_data.size(), N);
        for (int i = 0; i < cap_data.size(); i++) begin
            check("t5_data", cap_data[i], pl[i]);
        end
        rdy_mode = 0;
        idle(2);

        // 6: reset mid-receive and mid-drain
        send_byte(8'hF3);
        for (int i = 0; i < 4; i++) send_byte(digits[i]);
        reset = 1'b1;
        idle(1);
        check("t6a_out_valid", out_valid, 0);
        check("t6a_busy", busy, 0);
        reset = 1'b0;
        send_frame(digits, 16'h29B1, 0);
        @(negedge clk4m);
        check("t6a_frame_ok", frame_ok, 1);
        idle(1);
        wait_idle("t6a");
        rdy_mode = 3;
        send_frame(digits, 16'h29B1, 0);
        wait_valid("t6b");
        idle(2);
        reset = 1'b1;
        idle(1);
        check("t6b_out_valid", out_valid, 0);
        check("t6b_busy", busy, 0);
        reset = 1'b0;
        rdy_mode = 0;
        send_frame(digits, 16'h29B1, 0);
        @(negedge clk4m);
        check("t6b_frame_ok", frame_ok, 1);
        idle(1);
        wait_idle("t6b_end");

        // random traffic: corruption, long gaps, stray bytes, random ready
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            rand_payload(pl);
            if ($urandom_range(0, 4) == 0) begin
                send_byte(($urandom_range(0, 1) == 0) ? 8'hFC : 8'h00);
            end
            send_frame(pl,
                       ref_crc(pl, N) ^
                       (($urandom_range(0, 3) == 0) ? 16'h0100 : 16'h0000),
                       ($urandom_range(0, 4) == 0) ? TO + 3 : 3);
            idle($urandom_range(0, 3));
            wait_idle("rand");
            idle($urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
